// File: rtl/oam_dma.sv
// oam_dma: copies DMA_LEN bytes from a CPU-selected page into OAM over a req/ack bus initiator.
// Optional feature macro: OAM_DMA_CPU_STALL_EN drives cpu_stall from busy; otherwise cpu_stall is tied low.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter int unsigned DMA_LEN      = 160
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_wdata,
  output logic [7:0]  reg_rdata,
  output logic        reg_rvalid,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [7:0]  m_wdata,
  input  logic [7:0]  m_rdata,
  input  logic        m_ack,
  output logic        busy,
  output logic        done,
  output logic        cpu_stall
);
  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DMA_LEN - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [7:0]       src_page_q, src_page_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             restart_q, restart_d;
  logic             m_req_q, m_req_d;
  logic             m_we_q, m_we_d;
  logic [15:0]      m_addr_q, m_addr_d;
  logic [7:0]       m_wdata_q, m_wdata_d;
  logic [7:0]       reg_rdata_q, reg_rdata_d;
  logic             reg_rvalid_q, reg_rvalid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic       trigger_c, ack_c, issue_c, fin_c;
  logic [7:0] eff_page_c;

  assign trigger_c  = reg_wr && (reg_addr == DMA_REG_ADDR);
  assign ack_c      = m_req_q && m_ack;
  // Pages E0..FF mirror C0..DF (echo RAM).
  assign eff_page_c = (src_page_q >= 8'hE0) ? (src_page_q - 8'h20) : src_page_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      src_page_q   <= 8'h00;
      idx_q        <= '0;
      restart_q    <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= 16'h0000;
      m_wdata_q    <= 8'h00;
      reg_rdata_q  <= 8'hFF;
      reg_rvalid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_page_q   <= src_page_d;
      idx_q        <= idx_d;
      restart_q    <= restart_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      reg_rdata_q  <= reg_rdata_d;
      reg_rvalid_q <= reg_rvalid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // A retrigger never cuts a request short: it is remembered and applied at the ack.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    restart_d  = restart_q;
    src_page_d = src_page_q;
    issue_c    = 1'b0;
    fin_c      = 1'b0;
    if (trigger_c) src_page_d = reg_wdata;
    case (state_q)
      IDLE: begin
        if (trigger_c) begin
          state_d   = RD;
          idx_d     = '0;
          restart_d = 1'b0;
        end
      end
      default: begin
        if (trigger_c && !m_req_q) begin
          state_d   = RD;
          idx_d     = '0;
          restart_d = 1'b0;
        end else if (ack_c) begin
          if (restart_q || trigger_c) begin
            state_d   = RD;
            idx_d     = '0;
            restart_d = 1'b0;
          end else if (state_q == RD) begin
            state_d = WR;
            issue_c = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            fin_c   = 1'b1;
          end else begin
            state_d = RD;
            idx_d   = idx_q + IDX_W'(1);
            issue_c = 1'b1;
          end
        end else if (trigger_c) begin
          restart_d = 1'b1;
        end else if (!m_req_q) begin
          issue_c = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    m_req_d   = issue_c || (m_req_q && !m_ack);
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    if (ack_c && (state_q == RD)) m_wdata_d = m_rdata;
    if (issue_c) begin
      m_we_d   = (state_d == WR);
      m_addr_d = (state_d == WR) ? (OAM_BASE + 16'(idx_d)) : {eff_page_c, idx_d};
    end
    busy_d       = (state_d != IDLE);
    done_d       = fin_c;
    reg_rvalid_d = reg_rd && (reg_addr == DMA_REG_ADDR);
    reg_rdata_d  = reg_rvalid_d ? src_page_q : reg_rdata_q;
  end

  assign m_req      = m_req_q;
  assign m_we       = m_we_q;
  assign m_addr     = m_addr_q;
  assign m_wdata    = m_wdata_q;
  assign reg_rdata  = reg_rdata_q;
  assign reg_rvalid = reg_rvalid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef OAM_DMA_CPU_STALL_EN
  logic cpu_stall_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cpu_stall_q <= 1'b0;
    else          cpu_stall_q <= busy_d;
  end
  assign cpu_stall = cpu_stall_q;
`else
  assign cpu_stall = 1'b0;
`endif

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: a bus target with programmable ack delay checks every request in order.
module tb_oam_dma;
  localparam logic [15:0] REG_A = 16'hFF46;
  localparam logic [15:0] OAM_A = 16'hFE00;
  localparam int          LEN   = 160;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk, reset_n;
  logic        reg_wr, reg_rd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata, reg_rdata;
  logic        reg_rvalid;
  logic        m_req, m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic        m_ack;
  logic        busy, done, cpu_stall;

  int   n_cmp, n_fail;
  exp_t exp_q[$];
  exp_t e;
  int   pops, done_cnt, busy_cyc, stall_bad, wcnt, ack_delay;
  bit   junk_ack, in_req;
  logic        snap_we;
  logic [15:0] snap_addr;
  logic [7:0]  snap_wdata;
  logic [7:0]  oam [0:LEN-1];
  logic        stall_exp;

  oam_dma #(.DMA_REG_ADDR(REG_A), .OAM_BASE(OAM_A), .DMA_LEN(LEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .done(done), .cpu_stall(cpu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef OAM_DMA_CPU_STALL_EN
  assign stall_exp = busy;
`else
  assign stall_exp = 1'b0;
`endif

  function automatic logic [7:0] src_byte(input logic [15:0] a);
    logic [7:0] r;
    r = (a[7:0] * 8'd7) + a[15:8];
    return r ^ 8'h5A;
  endfunction

  function automatic int oam_bad(input logic [7:0] page);
    int n = 0;
    for (int i = 0; i < LEN; i++)
      if (oam[i] !== src_byte({page, 8'(i)})) n++;
    return n;
  endfunction

  // Bus target + scoreboard: each new request is popped against the expected queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      in_req = 1'b0;
      m_ack  = 1'b0;
    end else begin
      if (busy) busy_cyc++;
      if (done) done_cnt++;
      if (cpu_stall !== stall_exp) stall_bad++;
      if (m_req) begin
        if (!in_req) begin
          in_req = 1'b1; wcnt = 0;
          snap_we = m_we; snap_addr = m_addr; snap_wdata = m_wdata;
          pops++;
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_req: got we=%0b addr=%h, required no request", m_we, m_addr);
          end else begin
            e = exp_q.pop_front();
            if (m_we !== e.we || m_addr !== e.addr || (e.we && m_wdata !== e.data)) begin
              n_fail++;
              $display("FAIL req_%0d: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                       pops, m_we, m_addr, m_wdata, e.we, e.addr, e.data);
            end
          end
        end else begin
          wcnt++;
          n_cmp++;
          if (m_we !== snap_we || m_addr !== snap_addr || m_wdata !== snap_wdata) begin
            n_fail++;
            $display("FAIL req_stable: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                     m_we, m_addr, m_wdata, snap_we, snap_addr, snap_wdata);
          end
        end
        if (wcnt >= ack_delay) begin
          m_ack  = 1'b1;
          in_req = 1'b0;
          if (!m_we) m_rdata = src_byte(m_addr);
          else if (m_addr >= OAM_A && m_addr < OAM_A + 16'(LEN)) oam[int'(m_addr - OAM_A)] = m_wdata;
        end else begin
          m_ack = 1'b0;
        end
      end else begin
        in_req  = 1'b0;
        m_ack   = junk_ack;
        m_rdata = 8'($urandom);
      end
    end
  end

  task automatic start_test(input int dly, input bit junk);
    ack_delay = dly; junk_ack = junk;
    pops = 0; done_cnt = 0; busy_cyc = 0; stall_bad = 0;
    for (int i = 0; i < LEN; i++) oam[i] = 8'hxx;
    exp_q.delete();
  endtask

  task automatic push_xfer(input logic [7:0] page);
    exp_t x;
    for (int i = 0; i < LEN; i++) begin
      x.we = 1'b0; x.addr = {page, 8'(i)}; x.data = 8'h00;
      exp_q.push_back(x);
      x.we = 1'b1; x.addr = OAM_A + 16'(i); x.data = src_byte({page, 8'(i)});
      exp_q.push_back(x);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    @(negedge clk); #1;
    reg_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d, output logic v);
    @(negedge clk); #1;
    reg_rd = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    d = reg_rdata; v = reg_rvalid;
    reg_rd = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pops(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (pops >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
    start_test(0, 1'b0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({m_req, m_we, busy, done, cpu_stall, reg_rvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 000000", {m_req, m_we, busy, done, cpu_stall, reg_rvalid});
    end
    n_cmp++;
    if (m_addr !== 16'h0000 || m_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_bus: got addr=%h data=%h, required 0000/00", m_addr, m_wdata);
    end
    n_cmp++;
    if (reg_rdata !== 8'hFF) begin
      n_fail++; $display("FAIL reset_rdata: got %h, required ff", reg_rdata);
    end
    #1 reset_n = 1'b1;
  endtask

  task automatic test_zero_wait;
    bit ok; logic [7:0] d; logic v;
    start_test(0, 1'b1);
    push_xfer(8'hC1);
    cpu_write(REG_A, 8'hC1);
    wait_done(1, 2000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL zw_timeout: got done_cnt=%0d, required 1", done_cnt); end
    repeat (5) @(negedge clk); #1;
    n_cmp++;
    if (done_cnt !== 1) begin n_fail++; $display("FAIL zw_done: got %0d, required 1", done_cnt); end
    n_cmp++;
    if (pops !== 320) begin n_fail++; $display("FAIL zw_reqs: got %0d, required 320", pops); end
    n_cmp++;
    if (busy_cyc !== 321) begin n_fail++; $display("FAIL zw_busy: got %0d, required 321", busy_cyc); end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL zw_left: got %0d, required 0", exp_q.size()); end
    n_cmp++;
    if (oam_bad(8'hC1) !== 0) begin n_fail++; $display("FAIL zw_oam: got %0d bad bytes, required 0", oam_bad(8'hC1)); end
    n_cmp++;
    if (stall_bad !== 0) begin n_fail++; $display("FAIL zw_stall: got %0d bad cycles, required 0", stall_bad); end
    cpu_read(REG_A, d, v);
    n_cmp++;
    if (d !== 8'hC1 || v !== 1'b1) begin n_fail++; $display("FAIL rd_reg: got %h/%b, required c1/1", d, v); end
    cpu_read(16'h1234, d, v);
    n_cmp++;
    if (d !== 8'hC1 || v !== 1'b0) begin n_fail++; $display("FAIL rd_other: got %h/%b, required c1/0", d, v); end
    junk_ack = 1'b0;
  endtask

  task automatic test_wait_states;
    bit ok;
    start_test(3, 1'b0);
    push_xfer(8'h81);
    cpu_write(REG_A, 8'h81);
    wait_done(1, 3000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL ws_timeout: got done_cnt=%0d, required 1", done_cnt); end
    repeat (5) @(negedge clk); #1;
    n_cmp++;
    if (done_cnt !== 1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL ws_end: got done=%0d left=%0d, required 1/0", done_cnt, exp_q.size());
    end
    n_cmp++;
    if (busy_cyc !== 1281) begin n_fail++; $display("FAIL ws_busy: got %0d, required 1281", busy_cyc); end
    n_cmp++;
    if (oam_bad(8'h81) !== 0 || stall_bad !== 0) begin
      n_fail++; $display("FAIL ws_data: got oam_bad=%0d stall_bad=%0d, required 0/0", oam_bad(8'h81), stall_bad);
    end
  endtask

  task automatic test_echo;
    bit ok; logic [7:0] d; logic v;
    start_test(1, 1'b0);
    push_xfer(8'hC3);
    cpu_write(REG_A, 8'hE3);
    wait_done(1, 2000, ok);
    repeat (3) @(negedge clk); #1;
    n_cmp++;
    if (!ok || done_cnt !== 1 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL echo_end: got done=%0d left=%0d, required 1/0", done_cnt, exp_q.size());
    end
    n_cmp++;
    if (oam_bad(8'hC3) !== 0) begin n_fail++; $display("FAIL echo_oam: got %0d bad, required 0", oam_bad(8'hC3)); end
    cpu_read(REG_A, d, v);
    n_cmp++;
    if (d !== 8'hE3 || v !== 1'b1) begin n_fail++; $display("FAIL echo_reg: got %h/%b, required e3/1", d, v); end
  endtask

  task automatic test_retrigger;
    bit ok;
    start_test(2, 1'b0);
    push_xfer(8'h80);
    cpu_write(REG_A, 8'h80);
    wait_pops(101, 1000, ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL rt_reach: got pops=%0d, required 101", pops); end
    exp_q.delete();
    push_xfer(8'hD0);
    reg_wr = 1'b1; reg_addr = REG_A; reg_wdata = 8'hD0;
    @(negedge clk); #1;
    reg_wr = 1'b0;
    wait_done(1, 4000, ok);
    repeat (5) @(negedge clk); #1;
    n_cmp++;
    if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL rt_done: got %0d, required 1", done_cnt); end
    n_cmp++;
    if (pops !== 421 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL rt_reqs: got pops=%0d left=%0d, required 421/0", pops, exp_q.size());
    end
    n_cmp++;
    if (oam_bad(8'hD0) !== 0) begin n_fail++; $display("FAIL rt_oam: got %0d bad, required 0", oam_bad(8'hD0)); end
  endtask

  task automatic test_final_retrigger;
    bit ok;
    start_test(0, 1'b0);
    push_xfer(8'h30);
    cpu_write(REG_A, 8'h30);
    wait_pops(320, 1000, ok);
    push_xfer(8'h31);
    reg_wr = 1'b1; reg_addr = REG_A; reg_wdata = 8'h31;
    @(negedge clk); #1;
    reg_wr = 1'b0;
    n_cmp++;
    if (!ok || done_cnt !== 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL fr_coincide: got done=%0d busy=%b, required 0/1", done_cnt, busy);
    end
    wait_done(1, 2000, ok);
    repeat (5) @(negedge clk); #1;
    n_cmp++;
    if (!ok || done_cnt !== 1 || pops !== 640 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL fr_end: got done=%0d pops=%0d left=%0d, required 1/640/0", done_cnt, pops, exp_q.size());
    end
    n_cmp++;
    if (oam_bad(8'h31) !== 0) begin n_fail++; $display("FAIL fr_oam: got %0d bad, required 0", oam_bad(8'h31)); end
  endtask

  task automatic test_reset_midway;
    bit ok; logic [7:0] d; logic v;
    start_test(1, 1'b0);
    push_xfer(8'h45);
    cpu_write(REG_A, 8'h45);
    wait_pops(161, 1000, ok);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (!ok || {m_req, m_we, busy, done, cpu_stall, reg_rvalid} !== 6'b0 ||
        m_addr !== 16'h0000 || m_wdata !== 8'h00 || reg_rdata !== 8'hFF) begin
      n_fail++;
      $display("FAIL mid_reset: got flags=%b addr=%h data=%h rdata=%h, required 000000/0000/00/ff",
               {m_req, m_we, busy, done, cpu_stall, reg_rvalid}, m_addr, m_wdata, reg_rdata);
    end
    exp_q.delete();
    @(negedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    n_cmp++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_nodone: got done=%0d busy=%b, required 0/0", done_cnt, busy);
    end
    cpu_read(REG_A, d, v);
    n_cmp++;
    if (d !== 8'h00 || v !== 1'b1) begin n_fail++; $display("FAIL mid_reg: got %h/%b, required 00/1", d, v); end
  endtask

  task automatic test_after_reset;
    bit ok;
    start_test(0, 1'b0);
    push_xfer(8'h07);
    cpu_write(REG_A, 8'h07);
    wait_done(1, 2000, ok);
    repeat (3) @(negedge clk); #1;
    n_cmp++;
    if (!ok || done_cnt !== 1 || busy_cyc !== 321 || exp_q.size() !== 0 || stall_bad !== 0) begin
      n_fail++; $display("FAIL ar_end: got done=%0d busy=%0d left=%0d stall_bad=%0d, required 1/321/0/0",
                         done_cnt, busy_cyc, exp_q.size(), stall_bad);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0;
    m_ack = 1'b0; m_rdata = 8'h00; junk_ack = 1'b0; in_req = 1'b0; ack_delay = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_echo();
    test_retrigger();
    test_final_retrigger();
    test_reset_midway();
    test_after_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'hFF46, CPU-visible DMA source-page register address.
REQ-002 SHALL have parameter OAM_BASE, default 16'hFE00, first destination address in OAM.
REQ-003 SHALL have parameter DMA_LEN, default 160, bytes per transfer (range 1..256).
REQ-004 SHALL have one clock and asynchronous active-low reset: clk  in  1  rising-edge clock for all state.
REQ-005 SHALL have reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have reg_wr  in  1  CPU write strobe, sampled at posedge clk.
REQ-007 SHALL have reg_rd  in  1  CPU read strobe, sampled at posedge clk.
REQ-008 SHALL have reg_addr  in  16  CPU address.
REQ-009 SHALL have reg_wdata  in  8  CPU write data.
REQ-010 SHALL have reg_rdata  out  8  registered read data; valid the cycle after reg_rd.
REQ-011 SHALL have reg_rvalid  out  1  high one cycle when reg_rdata carries a read of DMA_REG_ADDR.
REQ-012 SHALL have m_req  out  1  bus-initiator request, held until acknowledged.
REQ-013 SHALL have m_we  out  1  1 = write, 0 = read; stable while m_req high.
REQ-014 SHALL have m_addr  out  16  initiator address; stable while m_req high.
REQ-015 SHALL have m_wdata  out  8  initiator write data; stable while m_req high.
REQ-016 SHALL have m_rdata  in  8  read data, valid in the m_ack cycle of a read.
REQ-017 SHALL have m_ack  in  1  target acknowledge; completes the request in that cycle.
REQ-018 SHALL have busy  out  1  high from the cycle after the trigger write until transfer end.
REQ-019 SHALL have done  out  1  one-cycle pulse after the last OAM write is acknowledged.
REQ-020 SHALL have cpu_stall  out  1  CPU hold request (see Configuration).

Function
REQ-021 SHALL treat reg_wr with reg_addr==DMA_REG_ADDR as a trigger: latch reg_wdata into src_page, clear byte index idx to 0.
REQ-022 SHALL use FSM states IDLE, RD, WR: IDLE->RD on trigger; RD->WR on m_ack (capture m_rdata); WR->RD on m_ack with idx<DMA_LEN-1 (idx++); WR->IDLE on m_ack with idx==DMA_LEN-1, pulsing done.
REQ-023 SHALL drive in RD: m_req=1, m_we=0, m_addr={eff_page, idx[7:0]}; in WR: m_req=1, m_we=1, m_addr=OAM_BASE+idx, m_wdata=captured byte.
REQ-024 SHALL map eff_page = src_page-8'h20 when src_page>=8'hE0 (echo-RAM mirror), else src_page.
REQ-025 SHALL assert m_req the cycle after entering RD/WR; m_req/m_addr/m_we/m_wdata SHALL NOT change until m_ack; m_req SHALL drop for at least zero cycles (back-to-back allowed) after ack.
REQ-026 SHALL tolerate m_ack asserted in the same cycle m_req first rises (zero-wait target).
REQ-027 SHALL on a trigger while busy (restart): finish the outstanding request, then restart at idx=0 with the new src_page; no done pulse for the aborted transfer.
REQ-028 SHALL on trigger coinciding with final WR ack: suppress done, restart at idx=0.
REQ-029 SHALL return src_page on reg_rd of DMA_REG_ADDR; other addresses: reg_rvalid=0, reg_rdata unchanged.
REQ-030 SHALL ignore m_ack while m_req is low.

Reset
REQ-031 SHALL on reset_n low, asynchronously: state=IDLE, src_page=8'h00, idx=0, m_req=0, m_we=0, m_addr=0, m_wdata=0, reg_rdata=8'hFF, reg_rvalid=0, busy=0, done=0, cpu_stall=0.
REQ-032 SHALL abandon any in-flight transfer on reset with no done pulse; first trigger after deassertion behaves as from IDLE.

Configuration
REQ-033 SHALL with OAM_DMA_CPU_STALL_EN defined drive cpu_stall=busy (registered identically); without it cpu_stall SHALL be constant 0 and all other behaviour identical.

Verification
REQ-034 SHALL cover: write 8'hC1 to FF46, zero-wait target -> 320 requests, reads C100..C19F, writes FE00..FE9F, OAM equals source, single done, busy high 320+1 cycles.
REQ-035 SHALL cover: target with 3-cycle ack delay -> m_req/m_addr/m_wdata stable during wait, data correct.
REQ-036 SHALL cover: write 8'hE3 -> reads from C300..C39F.
REQ-037 SHALL cover: retrigger with 8'hD0 at idx=50 -> no done for first, second transfer reads D000..D09F, one done total.
REQ-038 SHALL cover: reset_n low at idx=80 -> all outputs at reset values immediately; read FF46 afterwards -> 8'h00.
REQ-039 SHALL cover: run REQ-034 with and without OAM_DMA_CPU_STALL_EN -> cpu_stall tracks busy vs constant 0.
